booth4_pp_stage: RTL and testbench
==================================

BOOTH4_PP_STAGE -- requirements
Module: booth4_pp_stage

Interface
REQ-001 SHALL have ports: one clock; reset is synchronous and active-high; port names sys_clk and sys_rst.
REQ-002 sys_clk  input  1  rising-edge clock for all state.
REQ-003 sys_rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair on mcand_i/mplier_i is valid.
REQ-005 in_ready  output  1  stage accepts an operand pair this cycle.
REQ-006 mcand_i  input  16  signed two's-complement multiplicand X.
REQ-007 mplier_i  input  16  signed two's-complement multiplier Y.
REQ-008 out_valid  output  1  pp_o holds a valid partial-product set.
REQ-009 out_ready  input  1  downstream compressor accepts pp_o this cycle.
REQ-010 pp_o  output  144  8 partial products, 18-bit signed each; PPi at bits [18i+17:18i]; PPi is unshifted (weight 4^i applied downstream).

Function
REQ-011 Transfer SHALL occur on a rising edge with valid&ready high at the same interface; no transfer otherwise.
REQ-012 Pipeline SHALL be two register stages: S1 captures X, Y; S2 captures the 8 partial products computed from S1.
REQ-013 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high.
REQ-014 Throughput SHALL be one operand pair per cycle with out_ready held high.
REQ-015 S2 SHALL load when S1 is valid and (S2 empty or out_ready); S1 SHALL load when in_valid and (S1 empty or S1 advancing).
REQ-016 in_ready SHALL equal ~s1_valid | s2_load; combinational from out_ready, no path from in_valid.
REQ-017 While out_valid is high and out_ready low, pp_o and out_valid SHALL hold stable; no data lost or duplicated.
REQ-018 Booth digit i (i=0..7) SHALL be d_i = -2*Y[2i+1] + Y[2i] + Y[2i-1], with Y[-1]=0.
REQ-019 PPi SHALL equal d_i * X exactly, range ±65536, sign-extended to 18 bits; negation (+1) folded in, no separate correction bit.
REQ-020 -X and -2X SHALL be formed at 17/18 bits so X=-32768 yields +32768/+65536 without overflow.
REQ-021 Digit encodings 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
REQ-022 Invariant: sum over i of PPi*4^i SHALL equal X*Y as a signed 32-bit product.
REQ-023 Simultaneous S2 drain and S1 refill in one cycle SHALL be supported without bubble.

Reset
REQ-024 While sys_rst is high at a clock edge, s1_valid, s2_valid, out_valid SHALL clear to 0 and pp_o to all-zero.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; no output for them after reset.
REQ-027 Operand data registers need not reset; valid flags SHALL.

Structure
REQ-028 Shared package SHALL hold PP_W=18, PP_NUM=8, OP_W=16 and the 3-bit Booth digit encoding constants.
REQ-029 One combinational sub-module booth4_sel SHALL map (3-bit digit, X) to one 18-bit PP; instantiated 8 times via generate.
REQ-030 The pipeline control (valid flags, ready) SHALL live in booth4_pp_stage only.

Verification
REQ-031 X=3, Y=5, out_ready=1 -> 2 cycles later PP0=3, PP1=3, PP2..7=0.
REQ-032 X=5, Y=0x0003 -> PP0=0x3FFFB (-5), PP1=5, rest 0; weighted sum 15.
REQ-033 X=-32768 (0x8000), Y=-1 (0xFFFF) -> PP0=0x08000 (+32768), PP1..7=0; sum +32768.
REQ-034 X=1, Y=0xAAAA -> PP0=0x3FFFE (-2), PP1..7=0x3FFFF (-1); sum -21846.
REQ-035 Back-to-back stream of 4 pairs, out_ready low for 3 cycles after first out_valid -> in_ready drops after S1/S2 fill; all 4 results emerge in order, pp_o stable while stalled.
REQ-036 sys_rst pulsed one cycle with both stages full -> next cycle out_valid=0, pp_o=0, in_ready=1; no stale result appears later.

Source files
------------

// File: rtl/booth4_pp_stage_pkg.sv
// Shared widths and radix-4 Booth digit encodings for the partial-product stage.
package booth4_pp_stage_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PP_W   = 18;
    localparam int unsigned PP_NUM = 8;
    localparam int unsigned DIG_W  = 3;

    // Digit = {Y[2i+1], Y[2i], Y[2i-1]}
    localparam logic [DIG_W-1:0] BOOTH_ZERO_A = 3'b000;
    localparam logic [DIG_W-1:0] BOOTH_P1_A   = 3'b001;
    localparam logic [DIG_W-1:0] BOOTH_P1_B   = 3'b010;
    localparam logic [DIG_W-1:0] BOOTH_P2     = 3'b011;
    localparam logic [DIG_W-1:0] BOOTH_M2     = 3'b100;
    localparam logic [DIG_W-1:0] BOOTH_M1_A   = 3'b101;
    localparam logic [DIG_W-1:0] BOOTH_M1_B   = 3'b110;
    localparam logic [DIG_W-1:0] BOOTH_ZERO_B = 3'b111;

    typedef logic [PP_W-1:0]           pp_t;
    typedef pp_t [PP_NUM-1:0]          pp_vec_t;

endpackage

// File: rtl/booth4_sel.sv
// Maps one radix-4 Booth digit and multiplicand X to an exact 18-bit signed partial product.
module booth4_sel
    import booth4_pp_stage_pkg::*;
(
    input  logic [DIG_W-1:0] digit,
    input  logic [OP_W-1:0]  x,
    output logic [PP_W-1:0]  pp_c
);

    logic [PP_W-1:0] x1;
    logic [PP_W-1:0] x2;

    // Extend before negating so -(-32768) and -2*(-32768) stay representable.
    assign x1 = {{(PP_W-OP_W){x[OP_W-1]}}, x};
    assign x2 = {x1[PP_W-2:0], 1'b0};

    always_comb begin
        pp_c = '0;
        case (digit)
            BOOTH_ZERO_A, BOOTH_ZERO_B: pp_c = '0;
            BOOTH_P1_A, BOOTH_P1_B:     pp_c = x1;
            BOOTH_P2:                   pp_c = x2;
            BOOTH_M2:                   pp_c = -x2;
            BOOTH_M1_A, BOOTH_M1_B:     pp_c = -x1;
            default:                    pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth4_pp_stage.sv
// Two-stage valid/ready pipeline: S1 holds operands, S2 holds the eight Booth partial products.
module booth4_pp_stage
    import booth4_pp_stage_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        mcand_i,
    input  logic [OP_W-1:0]        mplier_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PP_NUM*PP_W-1:0] pp_o
);

    logic            s1_valid;
    logic            s2_valid;
    logic [OP_W-1:0] s1_x;
    logic [OP_W-1:0] s1_y;
    logic [OP_W:0]   y_ext;
    pp_vec_t         pp_d;
    pp_vec_t         pp_q;
    logic            s1_load;
    logic            s2_load;

    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    // Y with the implicit Y[-1] = 0 appended below bit 0.
    assign y_ext = {s1_y, 1'b0};

    for (genvar i = 0; i < PP_NUM; i++) begin : g_sel
        booth4_sel u_sel (
            .digit (y_ext[2*i+2 -: DIG_W]),
            .x     (s1_x),
            .pp_c  (pp_d[i])
        );
    end

    // Valid flags and the output register; drain and refill may coincide.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            pp_q     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= 1'b1;
                pp_q     <= pp_d;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (s1_load) begin
            s1_x <= mcand_i;
            s1_y <= mplier_i;
        end
    end

    assign out_valid = s2_valid;
    assign pp_o      = pp_q;

endmodule

// File: tb/tb_booth4_pp_stage.sv
// Directed and randomized scoreboard bench for the Booth radix-4 partial-product stage.
module tb_booth4_pp_stage;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  mcand_i;
    logic [15:0]  mplier_i;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] pp_o;

    typedef struct {
        logic [15:0]  x;
        logic [15:0]  y;
        logic [143:0] pp;
    } item_t;

    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    booth4_pp_stage dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand_i   (mcand_i),
        .mplier_i  (mplier_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp_o      (pp_o)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: digit value times X as plain integer arithmetic.
    function automatic logic [143:0] model_pp(input logic [15:0] x, input logic [15:0] y);
        logic [143:0] r;
        logic [16:0]  ye;
        r  = '0;
        ye = {y, 1'b0};
        for (int i = 0; i < 8; i++) begin
            int d;
            int p;
            d = -2 * int'(ye[2*i+2]) + int'(ye[2*i+1]) + int'(ye[2*i]);
            p = d * int'($signed(x));
            r[18*i +: 18] = 18'(p);
        end
        return r;
    endfunction

    function automatic int wsum(input logic [143:0] p);
        longint s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            logic signed [17:0] v;
            v = p[18*i +: 18];
            s += longint'(v) <<< (2*i);
        end
        return int'(s);
    endfunction

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        int n;
        n        = 0;
        in_valid = 1'b1;
        mcand_i  = x;
        mplier_i = y;
        @(negedge sys_clk);
        while (!in_ready && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 144'(in_ready), 144'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge sys_clk);
            sb_q.push_back('{x, y, model_pp(x, y)});
            #1 in_valid = 1'b0;
        end
    endtask

    // Send into an empty pipe with out_ready high; verify 2-cycle latency and the exact vector.
    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [143:0] exp);
        send(x, y);
        @(negedge sys_clk);
        chk({tag, "_lat1"}, 144'(out_valid), 144'(0));
        @(negedge sys_clk);
        chk({tag, "_lat2"}, 144'(out_valid), 144'(1));
        chk({tag, "_vec"}, pp_o, exp);
        @(posedge sys_clk);
        #1;
    endtask

    // Output monitor: every transfer must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (!sys_rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 144'(1), 144'(0));
            end else begin
                item_t it;
                it = sb_q.pop_front();
                chk("pp", pp_o, it.pp);
                chk("wsum", 144'(wsum(pp_o)), 144'(32'(int'($signed(it.x)) * int'($signed(it.y)))));
            end
        end
    end

    initial begin
        logic [143:0] e;
        logic         saw_low;
        int           t0;
        int           n;

        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        mcand_i   = '0;
        mplier_i  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        chk("rst_out_valid", 144'(out_valid), 144'(0));
        chk("rst_pp", pp_o, 144'(0));
        chk("rst_in_ready", 144'(in_ready), 144'(1));

        e = '0; e[17:0] = 18'd3; e[35:18] = 18'd3;
        directed("x3y5", 16'd3, 16'd5, e);
        e = '0; e[17:0] = 18'h3FFFB; e[35:18] = 18'd5;
        directed("x5y3", 16'd5, 16'h0003, e);
        e = '0; e[17:0] = 18'h08000;
        directed("xminy1", 16'h8000, 16'hFFFF, e);
        e = '0; e[17:0] = 18'h3FFFE;
        for (int i = 1; i < 8; i++) e[18*i +: 18] = 18'h3FFFF;
        directed("x1yaaaa", 16'd1, 16'hAAAA, e);

        // Throughput: three pairs accepted on consecutive edges.
        send(16'h7FFF, 16'h7FFF);
        t0 = cyc;
        send(16'h8000, 16'h8000);
        send(16'h1234, 16'hFEDC);
        chk("throughput", 144'(cyc - t0), 144'(2));
        repeat (4) @(posedge sys_clk);
        #1;

        // Back-to-back stream with a 3-cycle output stall.
        saw_low = 1'b0;
        fork
            begin
                send(16'd11, 16'd7);
                send(16'hFFF0, 16'h1357);
                send(16'h0100, 16'h8001);
                send(16'h8000, 16'h5555);
            end
            begin
                n = 0;
                do begin
                    @(posedge sys_clk);
                    #1;
                    n++;
                end while (!out_valid && n < 20);
                chk("stall_wait", 144'(out_valid), 144'(1));
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge sys_clk);
                    #1;
                    chk("stall_valid", 144'(out_valid), 144'(1));
                    if (sb_q.size() > 0) chk("stall_pp", pp_o, sb_q[0].pp);
                    if (!in_ready) saw_low = 1'b1;
                end
                out_ready = 1'b1;
            end
        join
        chk("in_ready_drop", 144'(saw_low), 144'(1));
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge sys_clk);
            n++;
        end
        #1 chk("stall_drain", 144'(sb_q.size()), 144'(0));

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        send(16'd9, 16'd9);
        send(16'd10, 16'd10);
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        sb_q.delete();
        chk("mid_rst_out_valid", 144'(out_valid), 144'(0));
        chk("mid_rst_pp", pp_o, 144'(0));
        chk("mid_rst_in_ready", 144'(in_ready), 144'(1));
        out_ready = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1 chk("no_stale", 144'(out_valid), 144'(0));

        // Random operands with random backpressure.
        fork
            begin
                for (int k = 0; k < 24; k++) send(16'($urandom), 16'($urandom));
            end
            begin
                repeat (60) begin
                    @(posedge sys_clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge sys_clk);
            n++;
        end
        #1 chk("rand_drain", 144'(sb_q.size()), 144'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
